// File: rtl/rgb_to_ycbcr422_tx.sv
// Purpose : RGB888 pixel stream to camera-style YCbCr 4:2:2 byte stream (Cb0 Y0 Cr0 Y1).
// Latency : Cb byte 2 clocks after the odd-pixel handshake when the serializer is idle.
// Backpr. : in_ready drops while an odd pixel would overwrite a pair not yet taken by the serializer.
//
// Ports:
//   PCLK, rst_n           pixel clock, synchronous active-low reset
//   in_valid/in_ready     RGB pixel handshake; in_sof marks pixel (0,0)
//   R, G, B               8-bit unsigned colour components
//   out_data/out_valid    one YCbCr byte per clock while serializing
//   out_sof, out_eol      flag the Cb byte of the (0,0) pair / the Y1 byte ending a line
//   x, y                  column/row of the last accepted pixel
// Build option: define CHROMA_AVG_EN to average Cb/Cr over the pixel pair;
//               otherwise the pair takes the even pixel's chroma.

module rgb_to_ycbcr422_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       PCLK,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol,
    output logic [9:0] x,
    output logic [9:0] y
);

    typedef enum logic [2:0] {IDLE, S_CB, S_Y0, S_CR, S_Y1} ser_state_t;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 20'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    // Colour conversion of the pixel currently on the input
    logic signed [19:0] r_s, g_s, b_s;
    logic signed [19:0] y_acc, cb_acc, cr_acc;
    logic [7:0]         y_cur, cb_cur, cr_cur;

    always_comb begin
        r_s    = {12'd0, R};
        g_s    = {12'd0, G};
        b_s    = {12'd0, B};
        y_acc  = 20'sd306 * r_s + 20'sd601 * g_s + 20'sd117 * b_s;
        cb_acc = 20'sd512 * b_s - 20'sd173 * r_s - 20'sd339 * g_s;
        cr_acc = 20'sd512 * r_s - 20'sd429 * g_s - 20'sd83 * b_s;
        y_cur  = clamp8(y_acc >>> 10);
        cb_cur = clamp8(20'sd128 + (cb_acc >>> 10));
        cr_cur = clamp8(20'sd128 + (cr_acc >>> 10));
    end

    // Pairing state
    logic       phase;          // 1 = next accepted pixel is the odd one
    logic [7:0] hold_y, hold_cb, hold_cr;
    logic       hold_sof;
    logic       pair_valid;
    logic [7:0] p_y0, p_y1, p_cb, p_cr;
    logic       p_sof, p_eol;

    // Serializer copies, so the pair register can refill while bytes go out
    ser_state_t state, state_nx;
    logic [7:0] sh_y0, sh_cr, sh_y1;
    logic       sh_eol;
    logic [7:0] data_nx;
    logic       vld_nx, sof_nx, eol_nx;

    logic       accept, is_even, load;
    logic [9:0] col_cur, row_cur;
    logic [8:0] cb_sum, cr_sum;

    assign in_ready = rst_n && !(phase && pair_valid);
    assign accept   = in_valid && in_ready;
    // in_sof restarts pairing: that pixel is always the even one
    assign is_even  = in_sof || !phase;
    assign load     = pair_valid && (state == IDLE || state == S_Y1);
    assign cb_sum   = {1'b0, hold_cb} + {1'b0, cb_cur};
    assign cr_sum   = {1'b0, hold_cr} + {1'b0, cr_cur};

    // Position of the pixel being accepted this cycle
    always_comb begin
        col_cur = x;
        row_cur = y;
        if (in_sof) begin
            col_cur = 10'd0;
            row_cur = 10'd0;
        end else if (x == 10'(H_ACTIVE - 1)) begin
            col_cur = 10'd0;
            row_cur = (y == 10'(V_ACTIVE - 1)) ? 10'd0 : y + 10'd1;
        end else begin
            col_cur = x + 10'd1;
        end
    end

    always_comb begin
        state_nx = IDLE;
        data_nx  = 8'd0;
        vld_nx   = 1'b0;
        sof_nx   = 1'b0;
        eol_nx   = 1'b0;
        case (state)
            IDLE, S_Y1: begin
                if (pair_valid) begin
                    state_nx = S_CB;
                    data_nx  = p_cb;
                    vld_nx   = 1'b1;
                    sof_nx   = p_sof;
                end
            end
            S_CB: begin
                state_nx = S_Y0;
                data_nx  = sh_y0;
                vld_nx   = 1'b1;
            end
            S_Y0: begin
                state_nx = S_CR;
                data_nx  = sh_cr;
                vld_nx   = 1'b1;
            end
            S_CR: begin
                state_nx = S_Y1;
                data_nx  = sh_y1;
                vld_nx   = 1'b1;
                eol_nx   = sh_eol;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            phase      <= 1'b0;
            pair_valid <= 1'b0;
            hold_y     <= 8'd0;
            hold_cb    <= 8'd0;
            hold_cr    <= 8'd0;
            hold_sof   <= 1'b0;
            p_y0       <= 8'd0;
            p_y1       <= 8'd0;
            p_cb       <= 8'd0;
            p_cr       <= 8'd0;
            p_sof      <= 1'b0;
            p_eol      <= 1'b0;
            sh_y0      <= 8'd0;
            sh_cr      <= 8'd0;
            sh_y1      <= 8'd0;
            sh_eol     <= 1'b0;
        end else begin
            if (load) begin
                pair_valid <= 1'b0;
                sh_y0      <= p_y0;
                sh_cr      <= p_cr;
                sh_y1      <= p_y1;
                sh_eol     <= p_eol;
            end
            // An odd accept needs pair_valid low, so it never collides with load
            if (accept) begin
                x <= col_cur;
                y <= row_cur;
                if (is_even) begin
                    hold_y   <= y_cur;
                    hold_cb  <= cb_cur;
                    hold_cr  <= cr_cur;
                    hold_sof <= (col_cur == 10'd0) && (row_cur == 10'd0);
                    phase    <= 1'b1;
                end else begin
                    p_y0       <= hold_y;
                    p_y1       <= y_cur;
`ifdef CHROMA_AVG_EN
                    p_cb       <= cb_sum[8:1];
                    p_cr       <= cr_sum[8:1];
`else
                    p_cb       <= hold_cb;
                    p_cr       <= hold_cr;
`endif
                    p_sof      <= hold_sof;
                    p_eol      <= (col_cur == 10'(H_ACTIVE - 1));
                    pair_valid <= 1'b1;
                    phase      <= 1'b0;
                end
            end
            state     <= state_nx;
            out_data  <= data_nx;
            out_valid <= vld_nx;
            out_sof   <= sof_nx;
            out_eol   <= eol_nx;
        end
    end

endmodule
